// File: rtl/sd_pkg.sv
// Shared types and defaults for the sequence-detector stream sequencer.
// The state encoding is shared by the controller and its bench.
package sd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SHIFT,
      GAP,
      DRAIN,
      REPORT
   } sd_state_e;

   localparam int WORD_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sd_sat_counter.sv
// Saturating up-counter with a synchronous clear and an increment enable.
// It holds at all-ones instead of wrapping.
module sd_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/sd_stream_ctrl.sv
// Frames parallel words onto a serial sequence detector and reports per-frame hit counts.
// All outputs are registered from the next-state decode, so they change in step with the state.
module sd_stream_ctrl
   import sd_pkg::*;
#(
   parameter int WORD_W    = WORD_W_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int CLR_CYC   = 1,
   parameter int DRAIN_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              sd_x,
   output logic              sd_clr,
   input  logic              sd_z,
   output logic              cnt_valid,
   output logic [CNT_W-1:0]  cnt_data,
   output logic              cnt_underrun,
   input  logic              cnt_ready,
   output logic              busy
);

   localparam int IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam int TMR_W = imax(1, $clog2(imax(CLR_CYC, DRAIN_CYC)));
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

   sd_state_e         state_reg, state_next;
   logic [WORD_W-1:0] shreg_reg, shreg_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [TMR_W-1:0]  tmr_reg, tmr_next;
   logic              last_reg, last_next;
   logic              underrun_reg, underrun_next;
   logic              sd_x_reg, sd_x_next;
   logic              sd_clr_reg, sd_clr_next;
   logic              in_ready_reg, in_ready_next;
   logic              cnt_valid_reg, cnt_valid_next;
   logic              busy_reg, busy_next;

   logic accept;
   logic cnt_clr;
   logic cnt_inc;

   assign accept  = in_valid && in_ready_reg;
   assign cnt_clr = (state_reg == IDLE) && accept;
   assign cnt_inc = sd_z && ((state_reg == SHIFT) || (state_reg == GAP) || (state_reg == DRAIN));

   sd_sat_counter #(
      .CNT_W (CNT_W)
   ) u_hits (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (cnt_data)
   );

   always_comb begin
      state_next    = state_reg;
      shreg_next    = shreg_reg;
      idx_next      = idx_reg;
      tmr_next      = tmr_reg;
      last_next     = last_reg;
      underrun_next = underrun_reg;
      sd_x_next     = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (accept) begin
               shreg_next    = in_data;
               last_next     = in_last;
               underrun_next = 1'b0;
               tmr_next      = '0;
               state_next    = CLEAR;
            end
         end
         CLEAR: begin
            if (tmr_reg == TMR_W'(CLR_CYC - 1)) begin
               sd_x_next  = shreg_reg[WORD_W-1];
               shreg_next = {shreg_reg[WORD_W-2:0], 1'b0};
               idx_next   = '0;
               state_next = SHIFT;
            end else begin
               tmr_next = tmr_reg + TMR_W'(1);
            end
         end
         SHIFT: begin
            if (idx_reg != IDX_LAST) begin
               sd_x_next  = shreg_reg[WORD_W-1];
               shreg_next = {shreg_reg[WORD_W-2:0], 1'b0};
               idx_next   = idx_reg + IDX_W'(1);
            end else if (accept) begin
               // Zero-gap chaining: the new word's MSB goes out on the very next cycle.
               sd_x_next  = in_data[WORD_W-1];
               shreg_next = {in_data[WORD_W-2:0], 1'b0};
               idx_next   = '0;
               last_next  = in_last;
            end else if (last_reg) begin
               tmr_next   = '0;
               state_next = DRAIN;
            end else begin
               underrun_next = 1'b1;
               state_next    = GAP;
            end
         end
         GAP: begin
            if (accept) begin
               sd_x_next  = in_data[WORD_W-1];
               shreg_next = {in_data[WORD_W-2:0], 1'b0};
               idx_next   = '0;
               last_next  = in_last;
               state_next = SHIFT;
            end
         end
         DRAIN: begin
            if (tmr_reg == TMR_W'(DRAIN_CYC - 1)) begin
               state_next = REPORT;
            end else begin
               tmr_next = tmr_reg + TMR_W'(1);
            end
         end
         REPORT: begin
            if (cnt_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Ready opens on the final bit of a non-last word so the next word can follow seamlessly.
      in_ready_next  = (state_next == IDLE) || (state_next == GAP) ||
                       ((state_next == SHIFT) && (idx_next == IDX_LAST) && !last_next);
      sd_clr_next    = (state_next == CLEAR);
      cnt_valid_next = (state_next == REPORT);
      busy_next      = (state_next != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         shreg_reg     <= '0;
         idx_reg       <= '0;
         tmr_reg       <= '0;
         last_reg      <= 1'b0;
         underrun_reg  <= 1'b0;
         sd_x_reg      <= 1'b0;
         sd_clr_reg    <= 1'b1;
         in_ready_reg  <= 1'b0;
         cnt_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shreg_reg     <= shreg_next;
         idx_reg       <= idx_next;
         tmr_reg       <= tmr_next;
         last_reg      <= last_next;
         underrun_reg  <= underrun_next;
         sd_x_reg      <= sd_x_next;
         sd_clr_reg    <= sd_clr_next;
         in_ready_reg  <= in_ready_next;
         cnt_valid_reg <= cnt_valid_next;
         busy_reg      <= busy_next;
      end
   end

   assign in_ready     = in_ready_reg;
   assign sd_x         = sd_x_reg;
   assign sd_clr       = sd_clr_reg;
   assign cnt_valid    = cnt_valid_reg;
   assign cnt_underrun = underrun_reg;
   assign busy         = busy_reg;

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// Directed bench for sd_stream_ctrl: a vector table for a single-word frame plus
// hand-written sequences for chaining, underrun, saturation, backpressure and reset.
module tb_sd_stream_ctrl;

   localparam int WORD_W = 8;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [WORD_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              in_ready;
   logic              sd_x;
   logic              sd_clr;
   logic              sd_z = 1'b0;
   logic              cnt_valid;
   logic [CNT_W-1:0]  cnt_data;
   logic              cnt_underrun;
   logic              cnt_ready = 1'b0;
   logic              busy;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sd_stream_ctrl #(
      .WORD_W    (WORD_W),
      .CNT_W     (CNT_W),
      .CLR_CYC   (1),
      .DRAIN_CYC (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .sd_x         (sd_x),
      .sd_clr       (sd_clr),
      .sd_z         (sd_z),
      .cnt_valid    (cnt_valid),
      .cnt_data     (cnt_data),
      .cnt_underrun (cnt_underrun),
      .cnt_ready    (cnt_ready),
      .busy         (busy)
   );

   typedef struct {
      logic             v;
      logic [7:0]       d;
      logic             l;
      logic             z;
      logic             cr;
      logic             ex;
      logic             eclr;
      logic             erdy;
      logic             evld;
      logic [CNT_W-1:0] ecnt;
      logic             eund;
      logic             ebusy;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                               input logic z, input logic cr, input logic ex,
                               input logic eclr, input logic erdy, input logic evld,
                               input logic [CNT_W-1:0] ecnt, input logic eund,
                               input logic ebusy);
      vec_t r;
      r.v = v; r.d = d; r.l = l; r.z = z; r.cr = cr;
      r.ex = ex; r.eclr = eclr; r.erdy = erdy; r.evld = evld;
      r.ecnt = ecnt; r.eund = eund; r.ebusy = ebusy;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[13];
      logic [15:0] pat;

      // Reset: outputs hold their reset values while rst is high
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_sd_clr", sd_clr, 1);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_cnt_valid", cnt_valid, 0);
         chk("rst_sd_x", sd_x, 0);
      end
      rst = 1'b0;
      step();
      chk("rel_sd_clr", sd_clr, 0);
      chk("rel_in_ready", in_ready, 1);
      chk("rel_busy", busy, 0);
      $display("reset sequence done: sd_clr=%0b in_ready=%0b", sd_clr, in_ready);

      // Single word A5, last; hits on bit 3, bit 6 and drain cycle 2
      //        v     d      l     z     cr    x     clr   rdy   vld   cnt   und   busy
      tv[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      tv[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      tv[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      tv[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      tv[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      tv[5]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
      tv[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
      tv[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
      tv[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1);
      tv[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1);
      tv[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1);
      tv[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
      tv[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         in_valid  = tv[i].v;
         in_data   = tv[i].d;
         in_last   = tv[i].l;
         sd_z      = tv[i].z;
         cnt_ready = tv[i].cr;
         step();
         chk("t2_sd_x", sd_x, tv[i].ex);
         chk("t2_sd_clr", sd_clr, tv[i].eclr);
         chk("t2_in_ready", in_ready, tv[i].erdy);
         chk("t2_cnt_valid", cnt_valid, tv[i].evld);
         chk("t2_cnt_data", cnt_data, tv[i].ecnt);
         chk("t2_underrun", cnt_underrun, tv[i].eund);
         chk("t2_busy", busy, tv[i].ebusy);
         $display("t2 vec %0d: sd_x=%0b sd_clr=%0b rdy=%0b vld=%0b cnt=%0d",
                  i, sd_x, sd_clr, in_ready, cnt_valid, cnt_data);
      end
      cnt_ready = 1'b0;

      // Back-to-back F0 then 0F with in_valid held: 16 contiguous bits
      pat = 16'hF00F;
      in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b0;
      step();
      chk("t3_clear", sd_clr, 1);
      in_data = 8'h0F; in_last = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         if (k == 8) in_valid = 1'b0;
         chk("t3_sd_x", sd_x, pat[15-k]);
         chk("t3_in_ready", in_ready, (k == 7) ? 1 : 0);
         $display("t3 bit %0d: sd_x=%0b in_ready=%0b", k, sd_x, in_ready);
      end
      step(); step(); step();
      chk("t3_cnt_valid", cnt_valid, 1);
      chk("t3_cnt_data", cnt_data, 0);
      chk("t3_underrun", cnt_underrun, 0);
      cnt_ready = 1'b1;
      step();
      chk("t3_done", cnt_valid, 0);
      cnt_ready = 1'b0;

      // Underrun: FF (not last), 3 idle cycles, then 00 (last)
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b0;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("t4_ff_bit", sd_x, 1);
      end
      for (int g = 0; g < 3; g++) begin
         step();
         if (g == 2) begin
            in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1;
         end
         chk("t4_gap_sd_x", sd_x, 0);
         chk("t4_gap_ready", in_ready, 1);
         chk("t4_gap_underrun", cnt_underrun, 1);
         $display("t4 gap %0d: sd_x=%0b in_ready=%0b underrun=%0b", g, sd_x, in_ready, cnt_underrun);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         in_valid = 1'b0;
         chk("t4_zero_bit", sd_x, 0);
         chk("t4_not_gap", in_ready, 0);
      end
      step(); step(); step();
      chk("t4_cnt_valid", cnt_valid, 1);
      chk("t4_underrun", cnt_underrun, 1);
      cnt_ready = 1'b1;
      step();
      cnt_ready = 1'b0;

      // Saturation: z held through CLEAR (ignored), 16 bits and drain -> 15
      in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; sd_z = 1'b1;
      step();
      in_data = 8'h55; in_last = 1'b1;
      for (int k = 0; k < 18; k++) begin
         step();
         if (k == 8) in_valid = 1'b0;
         chk("t5_cnt", cnt_data, (k < 15) ? k : 15);
      end
      step();
      sd_z = 1'b0;
      chk("t5_cnt_valid", cnt_valid, 1);
      chk("t5_cnt_sat", cnt_data, 15);
      chk("t5_underrun_clr", cnt_underrun, 0);
      $display("t5 report: cnt=%0d underrun=%0b", cnt_data, cnt_underrun);

      // Backpressure: report held while cnt_ready is low
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t6_hold_valid", cnt_valid, 1);
         chk("t6_hold_data", cnt_data, 15);
         chk("t6_hold_ready", in_ready, 0);
      end
      cnt_ready = 1'b1;
      step();
      cnt_ready = 1'b0;
      chk("t6_consumed", cnt_valid, 0);
      chk("t6_idle_ready", in_ready, 1);

      // Reset mid-SHIFT of a new frame
      in_valid = 1'b1; in_data = 8'hC3; in_last = 1'b1;
      step();
      in_valid = 1'b0; sd_z = 1'b1;
      step(); step(); step();
      chk("t6_in_shift", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_clr", sd_clr, 1);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_cnt", cnt_data, 0);
      sd_z = 1'b0;
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("t6_rel_ready", in_ready, 1);
      chk("t6_rel_clr", sd_clr, 0);
      for (int k = 0; k < 12; k++) begin
         step();
         chk("t6_no_report", cnt_valid, 0);
      end
      $display("t6 reset recovery: in_ready=%0b cnt_valid=%0b", in_ready, cnt_valid);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/sd_stream_ctrl.md
Name: sd_stream_ctrl

Overview:
Sequencer for the serial sequence_detector datapath (bit input x, detect output z).
- Accepts parallel words over a valid/ready stream.
- Clears the detector at the start of each frame, then shifts the words MSB-first onto the detector's serial input.
- Counts detector hits over the frame, including a post-frame drain window.
- Reports the per-frame hit count over a second valid/ready handshake.
- Sits between the host-side word source and one sequence_detector instance.

Parameters:
WORD_W, 8, bits per input word (>=2)
CNT_W, 8, width of the hit counter (saturating)
CLR_CYC, 1, cycles sd_clr is held high at frame start (>=1)
DRAIN_CYC, 2, cycles after the last bit during which sd_z is still counted (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input word valid
in_data  in  WORD_W  input word, transmitted MSB first
in_last  in  1  word is the last of its frame
in_ready  out  1  word accepted when in_valid && in_ready
sd_x  out  1  serial bit to detector x
sd_clr  out  1  detector reset, drives detector rst
sd_z  in  1  detector output z
cnt_valid  out  1  frame report valid
cnt_data  out  CNT_W  hits in frame
cnt_underrun  out  1  frame contained a stall gap
cnt_ready  in  1  report consumed when cnt_valid && cnt_ready
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values (async): state=IDLE, sd_clr=1, sd_x=0, in_ready=0, cnt_valid=0, cnt_data=0, cnt_underrun=0, busy=0.
- First clock after reset deassertion: sd_clr=0, in_ready=1.
- All outputs are registered. sd_clr=1 during rst keeps the detector in reset.
- IDLE:
  - in_ready=1, sd_x=0.
  - On accept: load shift register, latch in_last, clear counter and underrun, go to CLEAR.
- CLEAR:
  - sd_clr=1, sd_x=0, for exactly CLR_CYC cycles, then SHIFT.
  - sd_z is ignored.
- SHIFT:
  - sd_x = shreg[WORD_W-1]; shift left each cycle; bit index runs 0..WORD_W-1.
  - The first bit appears the cycle after CLEAR ends.
  - in_ready=1 only during the bit-index WORD_W-1 cycle, and only if the latched last flag is 0.
  - Accept in that cycle: next word's MSB follows with zero gap.
  - No accept at end of a non-last word: go to GAP.
  - Latched last=1: after bit WORD_W-1, go to DRAIN.
- GAP:
  - sd_x=0, in_ready=1, cnt_underrun sticky-set.
  - On accept, go to SHIFT with the new word; the first bit appears the next cycle.
  - Detector is not cleared.
- DRAIN:
  - sd_x=0, in_ready=0, for DRAIN_CYC cycles, then REPORT.
- REPORT:
  - cnt_valid=1; cnt_data and cnt_underrun held stable.
  - When cnt_ready=1, go to IDLE; cnt_valid drops the next cycle.
  - in_ready=0 throughout, so no new frame starts until the report is consumed.
- Hit counting:
  - counter += sd_z in every SHIFT, GAP and DRAIN cycle.
  - Saturates at 2^CNT_W-1; no wrap.
  - sd_z is sampled as-is, with no edge detect. A z held high for N counted cycles counts N.
- Simultaneous events:
  - Accept and the last bit in the same cycle: the word loads; no gap, no underrun.
  - cnt_ready high on the cycle cnt_valid first rises: the report completes in 1 cycle.
- Reset mid-operation (any state): immediately return to reset values.
  - Partial frame is discarded with no report.
  - sd_clr rises asynchronously with rst.
- in_last on a word accepted in GAP is honoured the same as in SHIFT.

Decomposition:
- Shared package sd_pkg:
  - state encoding enum (IDLE, CLEAR, SHIFT, GAP, DRAIN, REPORT)
  - default constants WORD_W_DEF, CNT_W_DEF
- One natural sub-module: sd_sat_counter.
  - CNT_W-bit saturating counter with sync clear and increment enable, async reset.
- Shift register, bit index and cycle timers stay inline.

Test Plan:
Benches drive sd_z directly (scripted pulses) so results do not depend on the detector pattern; one integration test uses the real sequence_detector.
1. Reset: hold rst=1 for 3 cycles -> sd_clr=1, in_ready=0, cnt_valid=0, sd_x=0. First cycle after release -> sd_clr=0, in_ready=1, busy=0.
2. Single word in_data=8'hA5, in_last=1:
   - sd_clr high 1 cycle, then sd_x=1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0.
   - sd_z pulsed on bits 3 and 6 and drain cycle 2 -> cnt_data=3, cnt_underrun=0.
3. Back-to-back frame 8'hF0 (last=0) then 8'h0F (last=1), in_valid held:
   - 16 contiguous bits 1111000000001111, no gap.
   - in_ready high only on bit-7 cycle.
   - sd_z never pulsed -> cnt_data=0.
4. Underrun: first word 8'hFF last=0, in_valid low for 3 cycles after it, then 8'h00 last=1:
   - sd_x=0 for exactly 3 GAP cycles, then 8 zero bits.
   - cnt_underrun=1.
5. Saturation with CNT_W=4: sd_z held 1 through SHIFT+DRAIN of a 2-word frame (18 counted cycles) -> cnt_data=15.
6. Backpressure and reset:
   - cnt_ready=0 for 5 cycles -> cnt_valid and cnt_data stable, in_ready=0 throughout.
   - rst asserted mid-SHIFT of a new frame -> no report; first cycle after release -> in_ready=1.
